ula_contention: RTL and testbench
=================================

# ula_contention

Sequencer for the shared video/CPU RAM inside the ULA, clocked at the 14 MHz ULA rate. It derives the CPU T-state tick (3.5 MHz, or 7.0 MHz in turbo) and runs the 8-slot display fetch pattern. It withholds the CPU clock enable while the video fetcher owns RAM, reproducing Spectrum memory contention (delays 6,5,4,3,2,1,0,0). It sits between the clock generator and the video fetcher/CPU, replacing the free-running CPU clock divider.

## Interface
Parameters:
- CONT_SLOTS, 6: slots 0..CONT_SLOTS-1 of each 8-slot group are owned by video; legal range 0..8.
- FETCH_SLOTS, 4: slots 0..FETCH_SLOTS-1 issue a fetch strobe; must be ≤ CONT_SLOTS.

Ports (one clock; reset is asynchronous and active-low):
- clk_ula  in  1  14 MHz ULA clock; all state on its rising edge.
- nreset  in  1  asynchronous active-low reset.
- turbo  in  1  1 = T-state tick every 2 clk_ula, 0 = every 4.
- vid_active  in  1  display-area fetch window (from video timing).
- cpu_contended  in  1  CPU is presenting a contended access (0x4000–0x7FFF memory or even-port I/O) this T-state.
- tick  out  1  one-clk_ula pulse marking a T-state boundary.
- cpu_ce  out  1  CPU clock enable; tick with stalls removed.
- vid_gnt  out  1  video owns RAM in the current slot.
- fetch_stb  out  1  one-cycle strobe: video performs a RAM read now.
- fetch_idx  out  2  fetch index at fetch_stb (0 bitmap0, 1 attr0, 2 bitmap1, 3 attr1).
- stall_cnt  out  3  T-states the last completed stall lasted (saturates at 7).
- stalling  out  1  CPU currently held.

## Operation
- Divider div[1:0] increments every clk_ula, wrapping. tick = (div==3) when turbo=0; tick = div[0] when turbo=1. turbo is sampled only when div==3, so a mode change never yields a tick gap shorter than 2 clocks or longer than 4.
- Slot counter slot[2:0]: held at 0 while vid_active=0; when vid_active=1, increments by 1 (7 wraps to 0) on each tick. Slot counter advances regardless of CPU stall.
- vid_gnt = vid_active & (slot < CONT_SLOTS), registered on tick.
- fetch_stb = tick & vid_active & (slot < FETCH_SLOTS); fetch_idx = slot[1:0].
- stall condition = tick & cpu_contended & vid_gnt. cpu_ce = tick & ~stall condition.
- stalling goes 1 on the first stalled tick, 0 on the next tick that produces cpu_ce.
- Stall length counter counts stalled ticks (saturating at 7); on the releasing cpu_ce it is copied into stall_cnt and cleared. A tick with no stall leaves stall_cnt unchanged.
- cpu_contended deasserting mid-stall releases the CPU on the next tick.
- vid_active falling mid-stall: slot forces to 0, vid_gnt drops, CPU released on next tick.
- CONT_SLOTS=0: no contention; cpu_ce == tick at all times.

## Timing
- Reset (asynchronous, nreset=0): div=0, slot=0, all outputs 0 (tick, cpu_ce, vid_gnt, fetch_stb, fetch_idx=0, stall_cnt=0, stalling=0). First tick 4 clk_ula after release (turbo=0) or 2 (turbo=1).
- Reset asserted mid-stall: cpu_ce stays 0 until the first post-reset tick; no partial stall is reported.
- All outputs registered; tick, cpu_ce, fetch_stb are single-cycle pulses, coincident with each other.
- Contention delay when the CPU first requests in slot s (vid_active, CONT_SLOTS=6): max(0, 6−s) T-states, i.e. 6,5,4,3,2,1,0,0 for s=0..7.
- cpu_ce never appears more often than tick; during a stall, there is zero cpu_ce.

## Test plan
- Reset and free run, turbo=0, vid_active=0: ticks every 4 clk_ula, first at cycle 4 after nreset rises; cpu_ce==tick; vid_gnt=0, fetch_stb never.
- turbo toggled 0→1 mid-run: tick spacing changes from 4 to 2 only after div==3; no gap <2 or >4.
- vid_active=1, cpu_contended held 1 from slot 0: 6 ticks with no cpu_ce, cpu_ce at slot 6 and 7, stall_cnt=6, stalling high 6 T-states; fetch_stb at slots 0–3 with fetch_idx 0,1,2,3.
- Contended request first presented at each slot s=0..7 (single request, released after its cpu_ce): measured stall 6,5,4,3,2,1,0,0 and stall_cnt matches.
- vid_active dropped at slot 2 during stall: CPU released on next tick, stall_cnt=3, slot=0.
- nreset pulsed during a stall at slot 3: all outputs 0 immediately; after release, first cpu_ce at 4th clock, stall_cnt=0.

Source files
------------

// File: rtl/ula_contention_if.sv
// Signal bundle between the ULA RAM sequencer and its neighbours.
// The master side drives the request inputs. The slave side drives the timing outputs.
interface ula_contention_if;
  logic       turbo;
  logic       vid_active;
  logic       cpu_contended;
  logic       tick;
  logic       cpu_ce;
  logic       vid_gnt;
  logic       fetch_stb;
  logic [1:0] fetch_idx;
  logic [2:0] stall_cnt;
  logic       stalling;

  modport master (
    output turbo, vid_active, cpu_contended,
    input  tick, cpu_ce, vid_gnt, fetch_stb, fetch_idx, stall_cnt, stalling
  );

  modport slave (
    input  turbo, vid_active, cpu_contended,
    output tick, cpu_ce, vid_gnt, fetch_stb, fetch_idx, stall_cnt, stalling
  );
endinterface

// File: rtl/ula_contention.sv
// Shared video/CPU RAM sequencer: T-state divider, 8-slot display fetch pattern,
// and a CPU clock enable that is withheld while video owns a contended slot.
module ula_contention #(
  parameter int CONT_SLOTS  = 6,
  parameter int FETCH_SLOTS = 4
) (
  input  logic            clk_ula,
  input  logic            nreset,
  ula_contention_if.slave bus
);

  typedef enum logic {ST_RUN, ST_STALL} stall_st_t;

  stall_st_t  st_q, st_d;
  logic [1:0] div_q;
  logic       turbo_q;
  logic       mode_vld_q;
  logic [2:0] slot_q;
  logic [2:0] len_q, len_d;
  logic [2:0] scnt_p1, scnt_d;
  logic       tick_p1, ce_p1, gnt_p1, stb_p1;
  logic [1:0] idx_p1;

  logic       eff_turbo, tick_p0, own_p0, fetch_p0, stall_p0;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Stage p0: decide, from the current divider and slot, what the next edge publishes.
  // Until turbo has been latched once after reset, the live input selects the mode.
  always_comb begin
    eff_turbo = mode_vld_q ? turbo_q : bus.turbo;
    tick_p0   = (div_q == 2'd3) | (eff_turbo & div_q[0]);
    own_p0    = bus.vid_active & ({1'b0, slot_q} < 4'(CONT_SLOTS));
    fetch_p0  = bus.vid_active & ({1'b0, slot_q} < 4'(FETCH_SLOTS));
    stall_p0  = tick_p0 & bus.cpu_contended & own_p0;
  end

  always_ff @(posedge clk_ula or negedge nreset) begin
    if (!nreset) st_q <= ST_RUN;
    else         st_q <= st_d;
  end

  // The stall length is published only on the tick that releases the CPU.
  always_comb begin
    st_d   = st_q;
    len_d  = len_q;
    scnt_d = scnt_p1;
    if (tick_p0) begin
      if (stall_p0) begin
        st_d  = ST_STALL;
        len_d = sat_inc3(len_q);
      end else begin
        st_d = ST_RUN;
        if (st_q == ST_STALL) begin
          scnt_d = len_q;
          len_d  = 3'd0;
        end
      end
    end
  end

  // Stage p1: registered outputs, all pulses coincident with tick.
  always_ff @(posedge clk_ula or negedge nreset) begin
    if (!nreset) begin
      div_q      <= 2'd0;
      turbo_q    <= 1'b0;
      mode_vld_q <= 1'b0;
      slot_q     <= 3'd0;
      len_q      <= 3'd0;
      scnt_p1    <= 3'd0;
      tick_p1    <= 1'b0;
      ce_p1      <= 1'b0;
      gnt_p1     <= 1'b0;
      stb_p1     <= 1'b0;
      idx_p1     <= 2'd0;
    end else begin
      div_q <= div_q + 2'd1;
      if (div_q == 2'd3) begin
        turbo_q    <= bus.turbo;
        mode_vld_q <= 1'b1;
      end
      tick_p1 <= tick_p0;
      ce_p1   <= tick_p0 & ~stall_p0;
      stb_p1  <= tick_p0 & fetch_p0;
      if (tick_p0 & fetch_p0) idx_p1 <= slot_q[1:0];
      if (!bus.vid_active) begin
        slot_q <= 3'd0;
        gnt_p1 <= 1'b0;
      end else if (tick_p0) begin
        slot_q <= slot_q + 3'd1;
        gnt_p1 <= own_p0;
      end
      len_q   <= len_d;
      scnt_p1 <= scnt_d;
    end
  end

  assign bus.tick      = tick_p1;
  assign bus.cpu_ce    = ce_p1;
  assign bus.vid_gnt   = gnt_p1;
  assign bus.fetch_stb = stb_p1;
  assign bus.fetch_idx = idx_p1;
  assign bus.stall_cnt = scnt_p1;
  assign bus.stalling  = (st_q == ST_STALL);

endmodule

// File: tb/tb_ula_contention.sv
// Scoreboard bench for ula_contention: a cycle-level behavioural model queues expected
// outputs per clock, and an independent monitor pops and compares them.
module tb_ula_contention;
  localparam int CONT  = 6;
  localparam int FETCH = 4;

  logic clk_ula = 1'b0;
  logic nreset  = 1'b0;

  ula_contention_if bus();

  ula_contention #(.CONT_SLOTS(CONT), .FETCH_SLOTS(FETCH)) dut (
    .clk_ula (clk_ula),
    .nreset  (nreset),
    .bus     (bus)
  );

  always #5 clk_ula = ~clk_ula;

  typedef struct {
    bit         tick;
    bit         ce;
    bit         gnt;
    bit         stb;
    logic [1:0] idx;
    logic [2:0] scnt;
    bit         stl;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model state
  int m_k, m_slot, m_len, m_scnt, m_idx;
  bit m_stl, m_turbo, m_have, m_tick, m_ce;
  bit drv_turbo, drv_va, drv_cc;

  // monitor observations
  int mon_k, last_tk, first_tick, first_ce, obs_stall, obs_ce, obs_tick;

  int stall_tab [8] = '{6, 5, 4, 3, 2, 1, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: cycle budget expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_k = 0; m_slot = 0; m_len = 0; m_scnt = 0; m_idx = 0;
    m_stl = 0; m_turbo = 0; m_have = 0; m_tick = 0; m_ce = 0;
  endtask

  // Predict the outputs following the next rising edge, given the inputs now applied.
  task automatic step();
    exp_t e;
    bit own, fetch, stall;
    m_k++;
    m_tick = (m_k % 4 == 0) || ((m_k % 4 == 2) && (m_have ? m_turbo : drv_turbo));
    if (m_k % 4 == 0) begin
      m_turbo = drv_turbo;
      m_have  = 1'b1;
    end
    own   = drv_va && (m_slot < CONT);
    fetch = drv_va && (m_slot < FETCH);
    stall = m_tick && drv_cc && own;
    m_ce  = m_tick && !stall;
    if (m_tick) begin
      if (fetch) m_idx = m_slot % 4;
      if (stall) begin
        m_len = (m_len < 7) ? m_len + 1 : 7;
        m_stl = 1'b1;
      end else begin
        if (m_stl) begin
          m_scnt = m_len;
          m_len  = 0;
        end
        m_stl = 1'b0;
      end
    end
    if (!drv_va) m_slot = 0;
    else if (m_tick) m_slot = (m_slot + 1) % 8;
    e.tick = m_tick;
    e.ce   = m_ce;
    e.gnt  = own;
    e.stb  = m_tick && fetch;
    e.idx  = 2'(m_idx);
    e.scnt = 3'(m_scnt);
    e.stl  = m_stl;
    exp_q.push_back(e);
  endtask

  task automatic apply(input bit t, input bit va, input bit cc);
    drv_turbo = t; drv_va = va; drv_cc = cc;
    bus.turbo = t; bus.vid_active = va; bus.cpu_contended = cc;
  endtask

  task automatic drive(input bit t, input bit va, input bit cc);
    @(negedge clk_ula);
    apply(t, va, cc);
    step();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tick"},      int'(bus.tick), 0);
    chk({tag, "_cpu_ce"},    int'(bus.cpu_ce), 0);
    chk({tag, "_vid_gnt"},   int'(bus.vid_gnt), 0);
    chk({tag, "_fetch_stb"}, int'(bus.fetch_stb), 0);
    chk({tag, "_fetch_idx"}, int'(bus.fetch_idx), 0);
    chk({tag, "_stall_cnt"}, int'(bus.stall_cnt), 0);
    chk({tag, "_stalling"},  int'(bus.stalling), 0);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock arrives.
  task automatic do_reset(input bit t, input bit va, input bit cc);
    @(negedge clk_ula);
    nreset = 1'b0;
    #1;
    chk_zero_outputs("arst");
    model_reset();
    repeat (2) @(negedge clk_ula);
    apply(t, va, cc);
    nreset = 1'b1;
    step();
  endtask

  // Monitor: one expected entry per clock while out of reset.
  initial begin
    exp_t e;
    int   gap;
    forever begin
      @(posedge clk_ula);
      #1;
      if (!nreset) begin
        mon_k = 0; last_tk = 0; first_tick = 0; first_ce = 0;
        obs_stall = 0; obs_ce = 0; obs_tick = 0;
        continue;
      end
      mon_k++;
      if (exp_q.size() == 0) begin
        bound_fail("sb_underflow");
        continue;
      end
      e = exp_q.pop_front();
      chk("tick",      int'(bus.tick), int'(e.tick));
      chk("cpu_ce",    int'(bus.cpu_ce), int'(e.ce));
      chk("fetch_stb", int'(bus.fetch_stb), int'(e.stb));
      if (bus.tick) begin
        chk("vid_gnt",   int'(bus.vid_gnt), int'(e.gnt));
        chk("fetch_idx", int'(bus.fetch_idx), int'(e.idx));
        chk("stall_cnt", int'(bus.stall_cnt), int'(e.scnt));
        chk("stalling",  int'(bus.stalling), int'(e.stl));
        if (last_tk != 0) begin
          gap = mon_k - last_tk;
          chk("tick_gap_2_or_4", int'(gap == 2 || gap == 4), 1);
        end
        last_tk = mon_k;
        obs_tick++;
        if (first_tick == 0) first_tick = mon_k;
        if (bus.cpu_ce) begin
          obs_ce++;
          if (first_ce == 0) first_ce = mon_k;
        end else begin
          obs_stall++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    model_reset();
    apply(1'b0, 1'b0, 1'b0);

    // Reset held, then free run with video idle.
    repeat (3) @(negedge clk_ula);
    chk_zero_outputs("rst");
    nreset = 1'b1;
    step();
    repeat (40) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    chk("first_tick_cycle", first_tick, 4);
    chk("first_ce_cycle", first_ce, 4);

    // Turbo switched on at an arbitrary phase.
    repeat ($urandom_range(1, 7)) drive(1'b0, 1'b0, 1'b0);
    repeat (12) drive(1'b1, 1'b0, 1'b0);
    @(negedge clk_ula);
    #1 obs_tick = 0;
    repeat (16) begin
      apply(1'b1, 1'b0, 1'b0);
      step();
      @(negedge clk_ula);
    end
    apply(1'b1, 1'b0, 1'b0);
    step();
    @(posedge clk_ula);
    #2;
    chk("turbo_ticks_in_16", obs_tick, 8);
    repeat (12) drive(1'b0, 1'b0, 1'b0);

    // Contended from slot 0 through a full 8-slot group.
    do_reset(1'b0, 1'b1, 1'b1);
    g = 0;
    while (obs_tick < 8 && g < 200) begin
      drive(1'b0, 1'b1, 1'b1);
      g++;
    end
    if (g >= 200) bound_fail("full_group_budget");
    chk("group_stalled_ticks", obs_stall, 6);
    chk("group_ce_ticks", obs_ce, 2);
    chk("group_stall_cnt", int'(bus.stall_cnt), 6);

    // Single request first presented at each slot.
    for (int s = 0; s < 8; s++) begin
      do_reset(1'b0, 1'b1, 1'b0);
      g = 0;
      while (m_slot != s && g < 200) begin
        drive(1'b0, 1'b1, 1'b0);
        g++;
      end
      if (g >= 200) bound_fail("slot_seek_budget");
      @(posedge clk_ula);
      #2 obs_stall = 0;
      g = 0;
      do begin
        drive(1'b0, 1'b1, 1'b1);
        g++;
      end while (!(m_tick && m_ce) && g < 200);
      if (g >= 200) bound_fail("slot_release_budget");
      repeat (3) drive(1'b0, 1'b1, 1'b0);
      chk($sformatf("slot%0d_measured_stall", s), obs_stall, stall_tab[s]);
      chk($sformatf("slot%0d_stall_cnt", s), int'(bus.stall_cnt), stall_tab[s]);
    end

    // Display window closes during a stall after slots 0..2.
    do_reset(1'b0, 1'b1, 1'b1);
    g = 0;
    while (m_slot != 3 && g < 200) begin
      drive(1'b0, 1'b1, 1'b1);
      g++;
    end
    g = 0;
    do begin
      drive(1'b0, 1'b0, 1'b1);
      g++;
    end while (!(m_tick && m_ce) && g < 200);
    if (g >= 200) bound_fail("vid_drop_budget");
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    chk("vid_drop_stalled_ticks", obs_stall, 3);
    chk("vid_drop_stall_cnt", int'(bus.stall_cnt), 3);
    chk("vid_drop_vid_gnt", int'(bus.vid_gnt), 0);
    chk("vid_drop_stalling", int'(bus.stalling), 0);

    // Reset arriving in the middle of a stall at slot 3.
    do_reset(1'b0, 1'b1, 1'b1);
    g = 0;
    while (m_slot != 4 && g < 200) begin
      drive(1'b0, 1'b1, 1'b1);
      g++;
    end
    drive(1'b0, 1'b1, 1'b1);
    chk("pre_reset_stalling", int'(bus.stalling), 1);
    do_reset(1'b0, 1'b0, 1'b0);
    repeat (8) drive(1'b0, 1'b0, 1'b0);
    chk("post_reset_first_ce", first_ce, 4);
    chk("post_reset_stall_cnt", int'(bus.stall_cnt), 0);

    // Randomised traffic.
    do_reset(1'b0, 1'b0, 1'b0);
    begin
      bit t, va;
      t = 1'b0;
      va = 1'b0;
      repeat (1500) begin
        if ($urandom_range(0, 63) == 0) t = ~t;
        if ($urandom_range(0, 15) == 0) va = ~va;
        drive(t, va, 1'($urandom_range(0, 1)));
      end
    end

    @(posedge clk_ula);
    #2;
    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
